// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-back, write-allocate data cache controller
//   clk_i, rst_i (async, active-low)
//   p1_*  : CPU side  (req/write/addr/data in, data/stall out)
//   mem_* : memory side (enable/write/addr/line data out, line data/ack in)
//   hit_cnt_o, miss_cnt_o : statistics, live only when DCACHE_STATS_EN is defined
module dcache_ctrl #(
  parameter int NUM_LINES = 32,
  parameter int LINE_W    = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              p1_req_i,
  input  logic              p1_write_i,
  input  logic [31:0]       p1_addr_i,
  input  logic [31:0]       p1_data_i,
  output logic [31:0]       p1_data_o,
  output logic              p1_stall_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 27 - IDX_W;
  typedef enum logic [2:0] {IDLE, MISS, WRITEBACK, READMISS, READMISSOK} state_t;
  state_t              r_state;
  logic [LINE_W-1:0]   r_data [NUM_LINES];
  logic [TAG_W-1:0]    r_tag [NUM_LINES];
  logic [NUM_LINES-1:0] r_valid, r_dirty;
  logic                r_mem_en, r_mem_we;
  logic [31:0]         r_mem_addr;
  logic [LINE_W-1:0]   r_mem_data;
  logic [IDX_W-1:0]    w_idx;
  logic [TAG_W-1:0]    w_tag;
  logic [2:0]          w_sel;
  logic                w_hit, w_victim_dirty, w_unused;
  assign w_sel          = p1_addr_i[4:2];
  assign w_idx          = p1_addr_i[5 +: IDX_W];
  assign w_tag          = p1_addr_i[31 -: TAG_W];
  assign w_unused       = ^p1_addr_i[1:0];
  assign w_hit          = p1_req_i && r_state == IDLE && r_valid[w_idx] && r_tag[w_idx] == w_tag;
  assign w_victim_dirty = r_valid[w_idx] && r_dirty[w_idx];
  // Valid bits clear asynchronously, so no hit (and no stall) can be seen while in reset.
  assign p1_stall_o   = rst_i && p1_req_i && !w_hit;
  assign p1_data_o    = (w_hit && !p1_write_i) ? r_data[w_idx][{w_sel, 5'b0} +: 32] : '0;
  assign mem_enable_o = r_mem_en;
  assign mem_write_o  = r_mem_we;
  assign mem_addr_o   = r_mem_addr;
  assign mem_data_o   = r_mem_data;
  // Memory outputs are loaded on state entry and held until the ack.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= IDLE;
      r_valid    <= '0;
      r_dirty    <= '0;
      r_mem_en   <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (p1_req_i && !w_hit) r_state <= MISS;
          if (w_hit && p1_write_i) r_dirty[w_idx] <= 1'b1;
        end
        MISS: begin
          r_state    <= w_victim_dirty ? WRITEBACK : READMISS;
          r_mem_en   <= 1'b1;
          r_mem_we   <= w_victim_dirty;
          r_mem_addr <= {w_victim_dirty ? r_tag[w_idx] : w_tag, w_idx, 5'b0};
          r_mem_data <= w_victim_dirty ? r_data[w_idx] : '0;
        end
        WRITEBACK: if (mem_ack_i) begin
          r_state    <= READMISS;
          r_mem_we   <= 1'b0;
          r_mem_addr <= {w_tag, w_idx, 5'b0};
          r_mem_data <= '0;
        end
        READMISS: if (mem_ack_i) begin
          r_state        <= READMISSOK;
          r_mem_en       <= 1'b0;
          r_mem_addr     <= '0;
          r_valid[w_idx] <= 1'b1;
          r_dirty[w_idx] <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  // Data and tag arrays carry no reset; during reset the state is IDLE with no valid lines, so nothing is written.
  always_ff @(posedge clk_i) begin
    if (r_state == READMISS && mem_ack_i) begin
      r_data[w_idx] <= mem_data_i;
      r_tag[w_idx]  <= w_tag;
    end else if (w_hit && p1_write_i) begin
      r_data[w_idx][{w_sel, 5'b0} +: 32] <= p1_data_i;
    end
  end
`ifdef DCACHE_STATS_EN
  logic        r_stalled;
  logic [31:0] r_hit_cnt, r_miss_cnt;
  // r_stalled marks a request that has already missed, so its final retry hit is not counted.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_stalled  <= 1'b0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (r_state == IDLE && p1_req_i && !w_hit) begin
        r_miss_cnt <= r_miss_cnt + 32'd1;
        r_stalled  <= 1'b1;
      end
      if (w_hit) begin
        r_hit_cnt <= r_hit_cnt + {31'b0, !r_stalled};
        r_stalled <= 1'b0;
      end
    end
  end
  assign hit_cnt_o  = r_hit_cnt;
  assign miss_cnt_o = r_miss_cnt;
`else
  assign hit_cnt_o  = '0;
  assign miss_cnt_o = '0;
`endif
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed + random bench for dcache_ctrl against a line-level cache/memory model
module tb_dcache_ctrl;
`ifdef DCACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic         clk_i = 1'b0, rst_i = 1'b0;
  logic         p1_req_i = 1'b0, p1_write_i = 1'b0;
  logic [31:0]  p1_addr_i = '0, p1_data_i = '0, p1_data_o;
  logic         p1_stall_o, mem_enable_o, mem_write_o, mem_ack_i = 1'b0;
  logic [31:0]  mem_addr_o, hit_cnt_o, miss_cnt_o;
  logic [255:0] mem_data_o, mem_data_i = '0;
  always #5 clk_i = ~clk_i;
  dcache_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .p1_req_i(p1_req_i), .p1_write_i(p1_write_i), .p1_addr_i(p1_addr_i), .p1_data_i(p1_data_i),
    .p1_data_o(p1_data_o), .p1_stall_o(p1_stall_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
    .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
  );
  int checks = 0, errors = 0;
  int exp_hit = 0, exp_miss = 0, fixed_dly = -1;
  bit           mv [32], md [32];
  logic [21:0]  mt [32];
  logic [255:0] mline [32];
  logic [255:0] backing [logic [31:0]];
  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic get_line(input logic [31:0] la, output logic [255:0] ln);
    if (!backing.exists(la))
      backing[la] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    ln = backing[la];
  endtask
  task automatic serve(input bit wr, input logic [31:0] a, input logic [255:0] d);
    int n = 0;
    int dly;
    while (mem_enable_o !== 1'b1 && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    check("mem_enable", mem_enable_o, 1);
    check("mem_write", mem_write_o, wr);
    check("mem_addr", mem_addr_o, a);
    if (wr) check("mem_wdata", mem_data_o, d);
    else mem_data_i = d;
    dly = fixed_dly >= 0 ? fixed_dly : $urandom_range(0, 4);
    repeat (dly) begin
      @(negedge clk_i);
      check("mem_hold", {mem_enable_o, mem_write_o, mem_addr_o}, {1'b1, wr, a});
    end
    mem_ack_i = 1'b1;
    @(negedge clk_i);
    mem_ack_i = 1'b0;
  endtask
  task automatic idle_check();
    check("idle_stall", p1_stall_o, 0);
    check("idle_data", p1_data_o, 0);
    check("idle_mem", {mem_enable_o, mem_write_o, mem_addr_o, mem_data_o}, 0);
  endtask
  task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] d, input bit spur);
    int idx = int'(a[9:5]);
    int w = int'(a[4:2]);
    logic [21:0] tg = a[31:10];
    bit hit = mv[idx] && mt[idx] == tg;
    logic [255:0] ln;
    @(negedge clk_i);
    p1_req_i = 1'b1;
    p1_write_i = wr;
    p1_addr_i = a;
    p1_data_i = d;
    #1;
    check("stall_first", p1_stall_o, !hit);
    if (!hit) begin
      exp_miss++;
      if (spur) begin
        @(negedge clk_i);
        mem_ack_i = 1'b1;
        @(negedge clk_i);
        mem_ack_i = 1'b0;
      end
      if (mv[idx] && md[idx]) begin
        serve(1'b1, {mt[idx], a[9:5], 5'b0}, mline[idx]);
        backing[{mt[idx], a[9:5], 5'b0}] = mline[idx];
      end
      get_line({tg, a[9:5], 5'b0}, ln);
      serve(1'b0, {tg, a[9:5], 5'b0}, ln);
      mv[idx] = 1'b1;
      md[idx] = 1'b0;
      mt[idx] = tg;
      mline[idx] = ln;
      check("stall_readmissok", p1_stall_o, 1);
      @(negedge clk_i);
      check("stall_done", p1_stall_o, 0);
    end else exp_hit++;
    if (!wr) check("load_data", p1_data_o, mline[idx][w*32 +: 32]);
    else begin
      mline[idx][w*32 +: 32] = d;
      md[idx] = 1'b1;
    end
    @(negedge clk_i);
    p1_req_i = 1'b0;
    #1;
    idle_check();
  endtask
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    repeat (2) @(negedge clk_i);
    idle_check();
    p1_req_i = 1'b1;
    #1;
    check("reset_stall", p1_stall_o, 0);
    check("reset_cnt", {hit_cnt_o, miss_cnt_o}, 0);
    p1_req_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    fixed_dly = 10;
    access(1'b0, 32'h0000_0040, 32'h0, 1'b0);
    fixed_dly = -1;
    check("fill_word0", p1_data_o, 0);
    access(1'b1, 32'h0000_0044, 32'hDEAD_BEEF, 1'b0);
    check("store_hit_count", exp_hit, 1);
    access(1'b0, 32'h0000_0044, 32'h0, 1'b0);
    check("store_readback", mline[2][63:32], 32'hDEAD_BEEF);
    access(1'b0, 32'h0000_0440, 32'h0, 1'b0);
    check("backing_wb", backing[32'h0000_0040][63:32], 32'hDEAD_BEEF);
    check("hit_cnt", hit_cnt_o, STATS ? 32'd2 : 32'd0);
    check("miss_cnt", miss_cnt_o, STATS ? 32'd2 : 32'd0);
    @(negedge clk_i);
    mem_ack_i = 1'b1;
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    #1;
    idle_check();
    access(1'b0, 32'h0000_0448, 32'h0, 1'b0);
    access(1'b0, 32'h0000_0040, 32'h0, 1'b1);
    @(negedge clk_i);
    p1_req_i = 1'b1;
    p1_write_i = 1'b0;
    p1_addr_i = 32'h0000_83E0;
    n = 0;
    while (!(mem_enable_o === 1'b1) && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    check("rst_mid_readmiss", {mem_enable_o, mem_write_o}, 2'b10);
    #2 rst_i = 1'b0;
    #1;
    check("rst_mid_mem", {mem_enable_o, mem_addr_o}, 0);
    check("rst_mid_stall", p1_stall_o, 0);
    check("rst_mid_cnt", {hit_cnt_o, miss_cnt_o}, 0);
    for (int i = 0; i < 32; i++) begin
      mv[i] = 1'b0;
      md[i] = 1'b0;
    end
    exp_hit = 0;
    exp_miss = 0;
    @(negedge clk_i);
    p1_req_i = 1'b0;
    rst_i = 1'b1;
    access(1'b0, 32'h0000_83E0, 32'h0, 1'b0);
    check("rst_remiss", exp_miss, 1);
    for (int i = 0; i < 200; i++)
      access($urandom_range(0, 1) == 1, (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 5)
             | (32'($urandom_range(0, 7)) << 2), $urandom, $urandom_range(0, 7) == 0);
    check("final_hit_cnt", hit_cnt_o, STATS ? 32'(exp_hit) : 32'd0);
    check("final_miss_cnt", miss_cnt_o, STATS ? 32'(exp_miss) : 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
